// File: rtl/vga_pkg.sv
// Shared scancodes, mode/command encodings and default 640x480 timing for vga_rect_gen.
package vga_pkg;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_SPACE = 8'h29;

    localparam int DEF_H_VIS  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_VIS  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    typedef enum logic { MODE_RESIZE = 1'b0, MODE_MOVE = 1'b1 } mode_e;

    typedef enum logic [2:0] {
        CMD_NONE, CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT, CMD_SPACE
    } cmd_e;

    function automatic cmd_e decode_key(input logic [7:0] code);
        cmd_e cmd;
        case (code)
            KEY_UP:    cmd = CMD_UP;
            KEY_DOWN:  cmd = CMD_DOWN;
            KEY_LEFT:  cmd = CMD_LEFT;
            KEY_RIGHT: cmd = CMD_RIGHT;
            KEY_SPACE: cmd = CMD_SPACE;
            default:   cmd = CMD_NONE;
        endcase
        return cmd;
    endfunction
endpackage

// File: rtl/vga_timing.sv
// Raster counters with registered sync/de, the frame-boundary apply strobe and frame_start.
module vga_timing
    import vga_pkg::*;
#(
    parameter int   H_VIS    = DEF_H_VIS,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_VIS    = DEF_V_VIS,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = 1'b0,
    localparam int  H_TOT    = H_VIS + H_FP + H_SYNC + H_BP,
    localparam int  V_TOT    = V_VIS + V_FP + V_SYNC + V_BP,
    localparam int  HW       = $clog2(H_TOT),
    localparam int  VW       = $clog2(V_TOT)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [HW-1:0] hpos,
    output logic [VW-1:0] vpos,
    output logic          visible,
    output logic          apply,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          frame_start
);
    logic [HW-1:0] hpos_q, hpos_d;
    logic [VW-1:0] vpos_q, vpos_d;
    logic hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, frame_start_q, frame_start_d;
    logic h_act, v_act;

    always_comb begin
        hpos_d = hpos_q + HW'(1);
        vpos_d = vpos_q;
        if (hpos_q == HW'(H_TOT - 1)) begin
            hpos_d = '0;
            vpos_d = (vpos_q == VW'(V_TOT - 1)) ? '0 : vpos_q + VW'(1);
        end
        // one extra bit so a sync window ending exactly at the total still compares correctly
        h_act   = ({1'b0, hpos_q} >= (HW+1)'(H_VIS + H_FP)) &&
                  ({1'b0, hpos_q} <  (HW+1)'(H_VIS + H_FP + H_SYNC));
        v_act   = ({1'b0, vpos_q} >= (VW+1)'(V_VIS + V_FP)) &&
                  ({1'b0, vpos_q} <  (VW+1)'(V_VIS + V_FP + V_SYNC));
        visible = ({1'b0, hpos_q} < (HW+1)'(H_VIS)) && ({1'b0, vpos_q} < (VW+1)'(V_VIS));
        apply   = (hpos_q == HW'(H_TOT - 1)) && (vpos_q == VW'(V_VIS - 1));
        hsync_d = h_act ? SYNC_POL : ~SYNC_POL;
        vsync_d = v_act ? SYNC_POL : ~SYNC_POL;
        de_d    = visible;
        frame_start_d = (hpos_d == '0) && (vpos_d == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hpos_q        <= '0;
            vpos_q        <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign frame_start = frame_start_q;
endmodule

// File: rtl/vga_rect_gen.sv
// VGA timing plus a keyboard-driven overlay rectangle, updated only at the frame boundary.
// Define RECT_FILL_EN to paint the rectangle interior mid-scale instead of black.
module vga_rect_gen
    import vga_pkg::*;
#(
    parameter int   H_VIS    = DEF_H_VIS,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_VIS    = DEF_V_VIS,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = 1'b0,
    parameter int   CW       = 3,
    parameter int   BORDER   = 2,
    parameter int   STEP     = 4,
    parameter int   MIN_SZ   = 8,
    parameter int   INIT_L   = 312,
    parameter int   INIT_T   = 232,
    parameter int   INIT_W   = 16,
    parameter int   INIT_H   = 16,
    localparam int  HW       = $clog2(H_VIS + H_FP + H_SYNC + H_BP),
    localparam int  VW       = $clog2(V_VIS + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          key_valid,
    input  logic [7:0]    key_code,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] vr,
    output logic [CW-1:0] vg,
    output logic [CW-1:0] vb,
    output logic [HW-1:0] hpos,
    output logic [VW-1:0] vpos,
    output logic          mode,
    output logic          frame_start
);
    localparam logic [HW:0]   STEP_HX = (HW+1)'(STEP);
    localparam logic [VW:0]   STEP_VX = (VW+1)'(STEP);
    localparam logic [HW:0]   MIN_HX  = (HW+1)'(MIN_SZ + 2*STEP);
    localparam logic [VW:0]   MIN_VX  = (VW+1)'(MIN_SZ + 2*STEP);
    localparam logic [HW:0]   LIM_HX  = (HW+1)'(H_VIS);
    localparam logic [VW:0]   LIM_VX  = (VW+1)'(V_VIS);
    localparam logic [HW:0]   BRD_HX  = (HW+1)'(BORDER);
    localparam logic [VW:0]   BRD_VX  = (VW+1)'(BORDER);
    localparam logic [HW-1:0] STEP_H  = HW'(STEP);
    localparam logic [HW-1:0] STEP2_H = HW'(2*STEP);
    localparam logic [VW-1:0] STEP_V  = VW'(STEP);
    localparam logic [VW-1:0] STEP2_V = VW'(2*STEP);

    logic          visible, apply;
    logic [HW-1:0] l_q, l_d, w_q, w_d;
    logic [VW-1:0] t_q, t_d, h_q, h_d;
    mode_e         mode_q, mode_d;
    cmd_e          pend_q, pend_d, key_cmd;
    logic [CW-1:0] col_q, col_d;
    logic [HW:0]   l_x, w_x, x_x;
    logic [VW:0]   t_x, h_x, y_x;
    logic          in_rect, on_border;

    vga_timing #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(SYNC_POL)
    ) u_timing (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
        .visible(visible), .apply(apply), .hsync(hsync), .vsync(vsync),
        .de(de), .frame_start(frame_start)
    );

    // widened copies: every bound check happens one bit up so nothing can wrap past it
    assign l_x = {1'b0, l_q};
    assign w_x = {1'b0, w_q};
    assign t_x = {1'b0, t_q};
    assign h_x = {1'b0, h_q};
    assign x_x = {1'b0, hpos};
    assign y_x = {1'b0, vpos};
    assign key_cmd = decode_key(key_code);

    always_comb begin
        l_d    = l_q;
        w_d    = w_q;
        t_d    = t_q;
        h_d    = h_q;
        mode_d = mode_q;
        pend_d = pend_q;
        if (apply) begin
            pend_d = CMD_NONE;
            case (pend_q)
                CMD_UP: begin
                    if (mode_q == MODE_MOVE) begin
                        if (t_x >= STEP_VX) t_d = t_q - STEP_V;
                    end else if (t_x >= STEP_VX && t_x + h_x + STEP_VX <= LIM_VX) begin
                        t_d = t_q - STEP_V;
                        h_d = h_q + STEP2_V;
                    end
                end
                CMD_DOWN: begin
                    if (mode_q == MODE_MOVE) begin
                        if (t_x + h_x + STEP_VX <= LIM_VX) t_d = t_q + STEP_V;
                    end else if (h_x >= MIN_VX) begin
                        t_d = t_q + STEP_V;
                        h_d = h_q - STEP2_V;
                    end
                end
                CMD_LEFT: begin
                    if (mode_q == MODE_MOVE) begin
                        if (l_x >= STEP_HX) l_d = l_q - STEP_H;
                    end else if (l_x >= STEP_HX && l_x + w_x + STEP_HX <= LIM_HX) begin
                        l_d = l_q - STEP_H;
                        w_d = w_q + STEP2_H;
                    end
                end
                CMD_RIGHT: begin
                    if (mode_q == MODE_MOVE) begin
                        if (l_x + w_x + STEP_HX <= LIM_HX) l_d = l_q + STEP_H;
                    end else if (w_x >= MIN_HX) begin
                        l_d = l_q + STEP_H;
                        w_d = w_q - STEP2_H;
                    end
                end
                CMD_SPACE: mode_d = (mode_q == MODE_MOVE) ? MODE_RESIZE : MODE_MOVE;
                default: ;
            endcase
        end
        // a key landing on the apply cycle survives as the next frame's command
        if (key_valid && key_cmd != CMD_NONE) pend_d = key_cmd;
    end

    always_comb begin
        in_rect   = (x_x >= l_x) && (x_x < l_x + w_x) && (y_x >= t_x) && (y_x < t_x + h_x);
        on_border = (x_x < l_x + BRD_HX) || (x_x + BRD_HX >= l_x + w_x) ||
                    (y_x < t_x + BRD_VX) || (y_x + BRD_VX >= t_x + h_x);
        col_d = '0;
        if (visible && in_rect) begin
            if (on_border) col_d = '1;
`ifdef RECT_FILL_EN
            else col_d[CW-1] = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            l_q    <= HW'(INIT_L);
            w_q    <= HW'(INIT_W);
            t_q    <= VW'(INIT_T);
            h_q    <= VW'(INIT_H);
            mode_q <= MODE_RESIZE;
            pend_q <= CMD_NONE;
            col_q  <= '0;
        end else begin
            l_q    <= l_d;
            w_q    <= w_d;
            t_q    <= t_d;
            h_q    <= h_d;
            mode_q <= mode_d;
            pend_q <= pend_d;
            col_q  <= col_d;
        end
    end

    assign vr   = col_q;
    assign vg   = col_q;
    assign vb   = col_q;
    assign mode = mode_q;
endmodule

// File: tb/tb_vga_rect_gen.sv
// Bench for vga_rect_gen on a shrunken 40x29 raster; per-cycle model compare plus directed pixel probes.
module tb_vga_rect_gen;
    localparam int HV = 32, HFP = 2, HS = 4, HBP = 2, HT = 40;
    localparam int VV = 24, VFP = 1, VS = 2, VBP = 2, VT = 29;
    localparam int FRAME = HT * VT;
    localparam int SP = 0;
    localparam int BD = 2, ST = 2, MINS = 4;
    localparam int IL = 12, IT = 8, IW = 8, IH = 8;
    localparam int HW = 6, VW = 5;
`ifdef RECT_FILL_EN
    localparam int FILLV = 4;
`else
    localparam int FILLV = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          key_valid = 1'b0;
    logic [7:0]    key_code = 8'h00;
    logic          hsync, vsync, de, mode, frame_start;
    logic [2:0]    vr, vg, vb;
    logic [HW-1:0] hpos;
    logic [VW-1:0] vpos;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vga_rect_gen #(
        .H_VIS(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VIS(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(1'b0), .CW(3), .BORDER(BD), .STEP(ST), .MIN_SZ(MINS),
        .INIT_L(IL), .INIT_T(IT), .INIT_W(IW), .INIT_H(IH)
    ) dut (
        .clk(clk), .reset(rst_n), .key_valid(key_valid), .key_code(key_code),
        .hsync(hsync), .vsync(vsync), .de(de), .vr(vr), .vg(vg), .vb(vb),
        .hpos(hpos), .vpos(vpos), .mode(mode), .frame_start(frame_start)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int mt = 0, cyc = 0;
    int mL = IL, mT = IT, mW = IW, mH = IH, mmode = 0, mpend = 0;
    int last_fs = -1, hs_run = 0, vs_run = 0;
    bit hs_prev = 0, vs_prev = 0;

    function automatic bit valid_key(input int c);
        return c == 'h75 || c == 'h72 || c == 'h6B || c == 'h74 || c == 'h29;
    endfunction

    function automatic int pix(input int x, input int y);
        if (x >= HV || y >= VV) return 0;
        if (x < mL || x >= mL + mW || y < mT || y >= mT + mH) return 0;
        if (x < mL + BD || x >= mL + mW - BD || y < mT + BD || y >= mT + mH - BD) return 7;
        return FILLV;
    endfunction

    task automatic exec(input int c);
        if (c == 'h29) mmode = 1 - mmode;
        else if (mmode == 0) begin
            if (c == 'h75 && mT >= ST && mT + mH + ST <= VV) begin mT -= ST; mH += 2*ST; end
            if (c == 'h72 && mH >= MINS + 2*ST) begin mT += ST; mH -= 2*ST; end
            if (c == 'h6B && mL >= ST && mL + mW + ST <= HV) begin mL -= ST; mW += 2*ST; end
            if (c == 'h74 && mW >= MINS + 2*ST) begin mL += ST; mW -= 2*ST; end
        end else begin
            if (c == 'h75 && mT >= ST) mT -= ST;
            if (c == 'h72 && mT + mH + ST <= VV) mT += ST;
            if (c == 'h6B && mL >= ST) mL -= ST;
            if (c == 'h74 && mL + mW + ST <= HV) mL += ST;
        end
    endtask

    always @(posedge clk) begin : cmp
        int h, v, kv, kc, e_hs, e_vs, e_de, e_col, e_h, e_v, e_fs;
        bit hs_a, vs_a;
        if (!rst_n) begin
            mt = 0; mL = IL; mT = IT; mW = IW; mH = IH; mmode = 0; mpend = 0;
            last_fs = -1; hs_run = 0; vs_run = 0; hs_prev = 0; vs_prev = 0;
        end else begin
            h = mt % HT;
            v = mt / HT;
            kv = int'(key_valid);
            kc = int'(key_code);
            e_hs  = (h >= HV + HFP && h < HV + HFP + HS) ? SP : 1 - SP;
            e_vs  = (v >= VV + VFP && v < VV + VFP + VS) ? SP : 1 - SP;
            e_de  = (h < HV && v < VV) ? 1 : 0;
            e_col = pix(h, v);
            if (h == HT - 1 && v == VV - 1) begin
                exec(mpend);
                mpend = 0;
            end
            if (kv != 0 && valid_key(kc)) mpend = kc;
            mt = (mt + 1) % FRAME;
            cyc++;
            e_h  = mt % HT;
            e_v  = mt / HT;
            e_fs = (mt == 0) ? 1 : 0;
            #1;
            chk("hpos", int'(hpos), e_h);
            chk("vpos", int'(vpos), e_v);
            chk("hsync", int'(hsync), e_hs);
            chk("vsync", int'(vsync), e_vs);
            chk("de", int'(de), e_de);
            chk("vr", int'(vr), e_col);
            chk("vg", int'(vg), e_col);
            chk("vb", int'(vb), e_col);
            chk("mode", int'(mode), mmode);
            chk("frame_start", int'(frame_start), e_fs);
            // hand-derived pins on the raster: hsync starts after hpos 34, vsync on line 25
            hs_a = (int'(hsync) == SP);
            vs_a = (int'(vsync) == SP);
            if (hs_a) begin
                if (!hs_prev) chk("hsync_start_hpos", int'(hpos), 35);
                hs_run++;
            end else begin
                if (hs_prev) chk("hsync_width", hs_run, 4);
                hs_run = 0;
            end
            if (vs_a) begin
                if (!vs_prev) chk("vsync_start_vpos", int'(vpos), 25);
                vs_run++;
            end else begin
                if (vs_prev) chk("vsync_width", vs_run, 80);
                vs_run = 0;
            end
            hs_prev = hs_a;
            vs_prev = vs_a;
            if (frame_start) begin
                if (last_fs >= 0) chk("frame_period", cyc - last_fs, 1160);
                last_fs = cyc;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic press(input logic [7:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic press_at_apply(input logic [7:0] code);
        int n;
        n = 0;
        while (n < 2*FRAME) begin
            @(negedge clk);
            if (int'(hpos) == HT - 1 && int'(vpos) == VV - 1) break;
            n++;
        end
        if (n >= 2*FRAME) begin
            checks++; errors++;
            $display("FAIL apply_wait: no apply cycle seen, expected one within %0d cycles", 2*FRAME);
        end else begin
            key_valid = 1'b1;
            key_code  = code;
            @(negedge clk);
            key_valid = 1'b0;
        end
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (n < 2*FRAME) begin
            @(posedge clk); #2;
            if (frame_start) break;
            n++;
        end
        if (n >= 2*FRAME) begin
            checks++; errors++;
            $display("FAIL frame_wait: frame_start=0, expected a pulse within %0d cycles", 2*FRAME);
        end
    endtask

    // colour registered for pixel (x,y) shows up one cycle after hpos/vpos equal (x,y)
    task automatic probe(input string name, input int x, input int y, input int e);
        int px, py, n;
        n = 0;
        px = int'(hpos);
        py = int'(vpos);
        while (n < 3*FRAME) begin
            @(posedge clk); #2;
            if (px == x && py == y) break;
            px = int'(hpos);
            py = int'(vpos);
            n++;
        end
        if (n >= 3*FRAME) begin
            checks++; errors++;
            $display("FAIL %s: pixel never reached, expected colour %0d", name, e);
        end else begin
            chk(name, int'({vr, vg, vb}), e * 73);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hpos"}, int'(hpos), 0);
        chk({tag, "_vpos"}, int'(vpos), 0);
        chk({tag, "_hsync"}, int'(hsync), 1);
        chk({tag, "_vsync"}, int'(vsync), 1);
        chk({tag, "_de"}, int'(de), 0);
        chk({tag, "_col"}, int'({vr, vg, vb}), 0);
        chk({tag, "_mode"}, int'(mode), 0);
        chk({tag, "_fs"}, int'(frame_start), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #23;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // initial rectangle L=12 T=8 W=8 H=8
        probe("init_l_minus1", 11, 8, 0);
        probe("init_l", 12, 8, 7);
        probe("init_r", 19, 8, 7);
        probe("init_r_plus1", 20, 8, 0);
        probe("init_interior", 15, 11, FILLV);
        wait_frame();
        wait_frame();

        // resize up: nothing visible until the frame boundary, then T=6 H=12
        press(8'h75);
        probe("up_pending_row6", 12, 6, 0);
        probe("up_pending_row8", 12, 8, 7);
        wait_frame();
        probe("up_row5", 12, 5, 0);
        probe("up_row6", 12, 6, 7);
        probe("up_row17", 12, 17, 7);
        probe("up_row18", 12, 18, 0);

        // resize down three times: H 12 -> 8 -> 4, third rejected
        wait_frame();
        press(8'h72);
        wait_frame();
        probe("dn1_row15", 12, 15, 7);
        probe("dn1_row16", 12, 16, 0);
        wait_frame();
        press(8'h72);
        wait_frame();
        probe("dn2_row9", 12, 9, 0);
        probe("dn2_row13", 12, 13, 7);
        probe("dn2_row14", 12, 14, 0);
        wait_frame();
        press(8'h72);
        wait_frame();
        probe("dn3_row9", 12, 9, 0);
        probe("dn3_row13", 12, 13, 7);
        probe("dn3_row14", 12, 14, 0);
        press(8'h1C);

        // move mode, then left each frame: L 12 -> 0 and held there
        wait_frame();
        press(8'h29);
        wait_frame();
        chk("mode_move", int'(mode), 1);
        for (int i = 0; i < 8; i++) begin
            press(8'h6B);
            wait_frame();
        end
        probe("mv_col0", 0, 10, 7);
        probe("mv_col7", 7, 10, 7);
        probe("mv_col8", 8, 10, 0);
        chk("mode_still_move", int'(mode), 1);

        // right pending, left lands on the apply cycle: right runs now, left next frame
        press(8'h74);
        press_at_apply(8'h6B);
        probe("apk_col1", 1, 10, 0);
        probe("apk_col2", 2, 10, 7);
        probe("apk_col9", 9, 10, 7);
        probe("apk_col10", 10, 10, 0);
        wait_frame();
        probe("apk_back_col0", 0, 10, 7);

        // asynchronous reset in the middle of a visible line
        n = 0;
        while (n < 2*FRAME) begin
            @(posedge clk); #2;
            if (int'(hpos) == 3 && int'(vpos) == 10) break;
            n++;
        end
        if (n >= 2*FRAME) begin
            checks++; errors++;
            $display("FAIL midline_wait: position (3,10) not seen, expected within %0d cycles", 2*FRAME);
        end
        chk("pre_rst_col", int'(vr), 7);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        probe("post_rst_l_minus1", 11, 8, 0);
        probe("post_rst_l", 12, 8, 7);
        chk("post_rst_mode", int'(mode), 0);
        wait_frame();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vga_rect_gen.md
Name: vga_rect_gen

Overview:
- Parametrised VGA timing generator with an overlay rectangle that the user moves or resizes from keyboard scancodes.
- Sits between the PS/2 scancode decoder and the DAC pins.
- Generalises the existing sync-plus-box block:
  - configurable timing, sync polarity, colour depth, border, step and minimum size;
  - a resize/move mode FSM;
  - tear-free updates, applied only at the frame boundary.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync
- CW, 3, bits per colour channel
- BORDER, 2, rectangle border thickness (pixels)
- STEP, 4, move/resize increment (pixels)
- MIN_SZ, 8, minimum rectangle width/height
- INIT_L, 312, reset left edge
- INIT_T, 232, reset top edge
- INIT_W, 16, reset width
- INIT_H, 16, reset height

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- key_valid  in  1  one-cycle strobe; key_code is valid
- key_code  in  8  PS/2 make code
- hsync  out  1  horizontal sync, registered
- vsync  out  1  vertical sync, registered
- de  out  1  display enable, aligned with colour outputs
- vr, vg, vb  out  CW each  colour outputs, registered
- hpos  out  HW  horizontal counter, HW = $clog2(H_VIS+H_FP+H_SYNC+H_BP)
- vpos  out  VW  vertical counter, VW = $clog2(V_VIS+V_FP+V_SYNC+V_BP)
- mode  out  1  0 = RESIZE, 1 = MOVE
- frame_start  out  1  one-cycle pulse when hpos==0 && vpos==0

Behaviour:
- Counters:
  - hpos runs 0..H_TOT-1 and wraps; vpos increments on each hpos wrap and wraps at V_TOT-1.
  - Visible region is hpos<H_VIS && vpos<V_VIS.
- Sync:
  - hsync is active for hpos in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC).
  - vsync is active for vpos in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC).
  - Active level = SYNC_POL.
- Latency:
  - hsync, vsync, de and colour are registered one cycle after the hpos/vpos value they describe.
- Colour:
  - Border pixel: visible, inside [L, L+W) × [T, T+H), and within BORDER of any edge.
  - Border pixels are all-ones on every channel; all other pixels are zero; de=0 forces zero.
- Reset (reset==0):
  - hpos=vpos=0.
  - hsync=vsync=!SYNC_POL.
  - de=0, colours=0, mode=RESIZE, frame_start=0.
  - Rectangle = INIT_*; pending command cleared.
  - All rectangle coordinates are in visible space.
- Key capture:
  - key_valid with code 0x75 (up), 0x72 (down), 0x6B (left), 0x74 (right) or 0x29 (space) loads a one-deep pending register.
  - A later key before apply overwrites it (last wins). Other codes are ignored.
- Apply point: the cycle hpos==H_TOT-1 && vpos==V_VIS-1. Pending command executes and is cleared there.
- Key on the apply cycle: the old pending command executes and the new key becomes pending.
- FSM, state RESIZE (mode=0):
  - up: T-=STEP, H+=2·STEP; only if T≥STEP and T+H+STEP≤V_VIS.
  - down: T+=STEP, H-=2·STEP; only if H≥MIN_SZ+2·STEP.
  - left: L-=STEP, W+=2·STEP; only if L≥STEP and L+W+STEP≤H_VIS.
  - right: L+=STEP, W-=2·STEP; only if W≥MIN_SZ+2·STEP.
  - space → MOVE.
- FSM, state MOVE (mode=1):
  - Arrows translate by STEP, rejected unless the whole rectangle stays on-screen: T≥STEP for up; T+H+STEP≤V_VIS for down; same rule horizontally.
  - space → RESIZE.
- A rejected command is dropped with no partial update.
- Arithmetic is unsigned at widths HW/VW; comparisons use a one-bit-wider intermediate so no underflow can pass a check.

Optional Feature:
- Macro RECT_FILL_EN.
- Defined: interior (non-border) pixels of the rectangle output a fill colour of mid-scale on every channel, value 2^(CW-1); border is unchanged.
- Not defined: interior is black.
- Timing and latency are identical in both builds.

Decomposition:
- Package vga_pkg:
  - scancode constants KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT, KEY_SPACE;
  - mode enum (MODE_RESIZE, MODE_MOVE);
  - default 640×480 timing constants.
- Sub-module vga_timing: counters, sync and de generation, apply-point strobe, frame_start.
- Top level: key capture, FSM, rectangle registers, pixel colour.

Test Plan:
- Reset, then run 2 frames:
  - hsync is low for 96 clocks starting at hpos=656;
  - vsync is low for lines 490–491;
  - period is 800×525 clocks;
  - frame_start pulses once per frame.
- After reset, on line 232:
  - pixels 312–327 are 7/7/7 one cycle after their hpos;
  - hpos=311 and hpos=328 are black.
- Pulse 0x75 mid-frame:
  - no change until the apply point;
  - next frame T=228, H=24.
- Pulse 0x72 twice (one per frame):
  - H goes 16→8;
  - the second press is rejected (8 < 16) and H stays 8.
- 0x29 then 0x6B repeated 80 frames:
  - mode=1;
  - L decreases by 4 per frame to 0, then stays 0, with W=16 unchanged.
- Assert reset mid-line:
  - outputs return to reset values immediately;
  - after release, hpos restarts at 0 with the rectangle back at INIT_*.
